// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the MM:SS stopwatch.
// Optional STOPWATCH_BLINK_EN enables the adjust-mode blink divider.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    RUN,
    PAUSED,
    ADJUST
  } state_t;

  localparam int BCD_W     = 4;
  localparam int SEC_MAX   = 59;
  localparam int BLINK_DIV = 8;

  function automatic logic [2*BCD_W-1:0] to_bcd2(input int v);
    to_bcd2 = {BCD_W'(v / 10), BCD_W'(v % 10)};
  endfunction

endpackage

// File: rtl/stopwatch_if.sv
// stopwatch_if: display bundle from the stopwatch core to the
// 7-segment driver (four BCD digits, run flag, blink flags).
interface stopwatch_if;
  import stopwatch_pkg::*;

  logic [BCD_W-1:0] min_tens;
  logic [BCD_W-1:0] min_ones;
  logic [BCD_W-1:0] sec_tens;
  logic [BCD_W-1:0] sec_ones;
  logic             running;
  logic             blink_min;
  logic             blink_sec;

  modport master (
    output min_tens, min_ones,
    output sec_tens, sec_ones,
    output running,
    output blink_min, blink_sec
  );

  modport slave (
    input min_tens, min_ones,
    input sec_tens, sec_ones,
    input running,
    input blink_min, blink_sec
  );

endinterface

// File: rtl/stopwatch_bcd2_counter.sv
// bcd2_counter: two-digit BCD up-counter wrapping to 00 after the
// wrap value; carry_out flags the wrapping increment.
module bcd2_counter
  import stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic [BCD_W-1:0] wrap_tens,
  input  logic [BCD_W-1:0] wrap_ones,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             carry_out
);

  logic at_wrap;
  logic ones_nine;

  assign at_wrap   = (tens == wrap_tens) && (ones == wrap_ones);
  assign ones_nine = (ones == BCD_W'(9));
  assign carry_out = inc && at_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      unique case (1'b1)
        at_wrap: begin
          tens <= '0;
          ones <= '0;
        end
        (!at_wrap && ones_nine): begin
          ones <= '0;
          tens <= tens + BCD_W'(1);
        end
        default: ones <= ones + BCD_W'(1);
      endcase
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS stopwatch with run/pause and adjust modes.
// Define STOPWATCH_BLINK_EN to build the adjust-mode blink outputs.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN     = 59,
  parameter int ADJ_DIV     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        one_hz,
  input  logic        thirty_two_hz,
  input  logic        pause_btn,
  input  logic        adj,
  input  logic        sel,
  stopwatch_if.master disp
);

  localparam int ADJ_W = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
  localparam logic [2*BCD_W-1:0] SEC_WRAP = to_bcd2(SEC_MAX);
  localparam logic [2*BCD_W-1:0] MIN_WRAP = to_bcd2(MAX_MIN);

  // bit 0 one_hz, bit 1 thirty_two_hz, bit 2 pause_btn
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0]                  prev_q;
  logic [2:0]                  sync_last;
  logic [2:0]                  tick;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign tick      = sync_last & ~prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0],
                 {pause_btn, thirty_two_hz, one_hz}};
      prev_q <= sync_last;
    end
  end

  logic hz_tick;
  logic tt_tick;
  logic pb_tick;

  assign hz_tick = tick[0];
  assign tt_tick = tick[1];
  assign pb_tick = tick[2];

  state_t state;
  logic   running_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      running_q <= 1'b1;
    end else begin
      unique case (1'b1)
        adj: begin
          state     <= ADJUST;
          running_q <= 1'b0;
        end
        (!adj && state == ADJUST): begin
          state     <= PAUSED;
          running_q <= 1'b0;
        end
        (!adj && state != ADJUST && pb_tick): begin
          state     <= (state == RUN) ? PAUSED : RUN;
          running_q <= (state == PAUSED);
        end
        default: ;
      endcase
    end
  end

  assign disp.running = running_q;

  logic [ADJ_W-1:0] adj_div;
  logic             adj_last;
  logic             adj_fire;
  logic             in_adj;

  assign in_adj   = (state == ADJUST);
  assign adj_last = (adj_div == ADJ_W'(ADJ_DIV - 1));
  assign adj_fire = in_adj && tt_tick && adj_last;

  // held at zero outside ADJUST so every entry starts a fresh interval
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adj_div <= '0;
    end else if (!in_adj) begin
      adj_div <= '0;
    end else if (tt_tick) begin
      adj_div <= adj_last ? '0 : adj_div + ADJ_W'(1);
    end
  end

  logic sec_inc;
  logic min_inc;
  logic sec_carry;
  logic min_carry_unused;

  assign sec_inc = ((state == RUN) && hz_tick) || (adj_fire && sel);
  assign min_inc = ((state == RUN) && sec_carry) || (adj_fire && !sel);

  bcd2_counter u_sec (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (sec_inc),
    .wrap_tens (SEC_WRAP[2*BCD_W-1:BCD_W]),
    .wrap_ones (SEC_WRAP[BCD_W-1:0]),
    .tens      (disp.sec_tens),
    .ones      (disp.sec_ones),
    .carry_out (sec_carry)
  );

  bcd2_counter u_min (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (min_inc),
    .wrap_tens (MIN_WRAP[2*BCD_W-1:BCD_W]),
    .wrap_ones (MIN_WRAP[BCD_W-1:0]),
    .tens      (disp.min_tens),
    .ones      (disp.min_ones),
    .carry_out (min_carry_unused)
  );

`ifdef STOPWATCH_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_DIV);

  logic [BLINK_W-1:0] blink_div;
  logic               blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_div   <= '0;
      blink_phase <= 1'b0;
    end else if (!in_adj) begin
      blink_div   <= '0;
      blink_phase <= 1'b0;
    end else if (tt_tick) begin
      if (blink_div == BLINK_W'(BLINK_DIV - 1)) begin
        blink_div   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_div <= blink_div + BLINK_W'(1);
      end
    end
  end

  assign disp.blink_min = in_adj && !sel && blink_phase;
  assign disp.blink_sec = in_adj && sel && blink_phase;
`else
  assign disp.blink_min = 1'b0;
  assign disp.blink_sec = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed + random stimulus, reference model of
// MM:SS/state/blink, scoreboard queue drained by a monitor process.
module tb_stopwatch_core;

  localparam int MAXM = 59;
  localparam int ADJD = 16;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic one_hz = 1'b0;
  logic thirty_two_hz = 1'b0;
  logic pause_btn = 1'b0;
  logic adj = 1'b0;
  logic sel = 1'b0;

  stopwatch_if disp_if ();

  stopwatch_core #(
    .MAX_MIN     (MAXM),
    .ADJ_DIV     (ADJD),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .one_hz        (one_hz),
    .thirty_two_hz (thirty_two_hz),
    .pause_btn     (pause_btn),
    .adj           (adj),
    .sel           (sel),
    .disp          (disp_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic [18:0] vec;
  } exp_t;

  exp_t  q[$];
  event  smp;
  int    checks = 0;
  int    failures = 0;
  string phase_nm = "reset";

  // model: st 0=run 1=paused 2=adjust; n = 32 Hz ticks since adjust entry
  int m_mm, m_ss, m_st, m_n;
  bit m_sel;

  function automatic void m_reset();
    m_mm = 0; m_ss = 0; m_st = 0; m_n = 0;
  endfunction

  function automatic void m_sec();
    if (m_st == 0) begin
      m_ss++;
      if (m_ss == 60) begin
        m_ss = 0;
        m_mm = (m_mm == MAXM) ? 0 : m_mm + 1;
      end
    end
  endfunction

  function automatic void m_tt();
    if (m_st == 2) begin
      m_n++;
      if (m_n % ADJD == 0) begin
        if (m_sel) m_ss = (m_ss + 1) % 60;
        else m_mm = (m_mm == MAXM) ? 0 : m_mm + 1;
      end
    end
  endfunction

  function automatic void m_pause();
    if (m_st != 2) m_st = (m_st == 0) ? 1 : 0;
  endfunction

  function automatic void m_adj(input bit v);
    if (v && m_st != 2) begin
      m_st = 2;
      m_n = 0;
    end else if (!v && m_st == 2) begin
      m_st = 1;
    end
  endfunction

  function automatic logic [18:0] m_vec();
    bit ph, bm, bs;
    ph = ((m_n / 8) % 2) == 1;
`ifdef STOPWATCH_BLINK_EN
    bm = (m_st == 2) && !m_sel && ph;
    bs = (m_st == 2) && m_sel && ph;
`else
    bm = 1'b0;
    bs = 1'b0;
`endif
    return {4'(m_mm / 10), 4'(m_mm % 10), 4'(m_ss / 10), 4'(m_ss % 10),
            (m_st == 0), bm, bs};
  endfunction

  task automatic expect_now();
    exp_t e;
    e.name = phase_nm;
    e.vec = m_vec();
    q.push_back(e);
    ->smp;
  endtask

  initial begin : monitor
    exp_t e;
    logic [18:0] act;
    forever begin
      @(smp);
      while (q.size() > 0) begin
        e = q.pop_front();
        act = {disp_if.min_tens, disp_if.min_ones,
               disp_if.sec_tens, disp_if.sec_ones,
               disp_if.running, disp_if.blink_min, disp_if.blink_sec};
        checks++;
        if (act !== e.vec) begin
          failures++;
          $display("FAIL %s: got mm:ss=%h:%h run=%b bm=%b bs=%b, want mm:ss=%h:%h run=%b bm=%b bs=%b",
                   e.name, act[18:11], act[10:3], act[2], act[1], act[0],
                   e.vec[18:11], e.vec[10:3], e.vec[2], e.vec[1], e.vec[0]);
        end
      end
    end
  end

  task automatic drive(input int w, input logic v);
    case (w)
      0: one_hz = v;
      1: thirty_two_hz = v;
      2: pause_btn = v;
      default: begin
        one_hz = v;
        pause_btn = v;
      end
    endcase
  endtask

  // w: 0 one_hz, 1 thirty_two_hz, 2 pause_btn, 3 one_hz+pause_btn together
  task automatic step(input int w);
    drive(w, 1'b1);
    repeat (LAT + $urandom_range(0, 2)) @(negedge clk);
    drive(w, 1'b0);
    repeat (LAT + $urandom_range(0, 1)) @(negedge clk);
    case (w)
      0: m_sec();
      1: m_tt();
      2: m_pause();
      default: begin
        m_sec();
        m_pause();
      end
    endcase
    expect_now();
  endtask

  task automatic set_adj(input bit v);
    adj = v;
    repeat (LAT) @(negedge clk);
    m_adj(v);
    expect_now();
  endtask

  task automatic set_sel(input bit v);
    sel = v;
    @(negedge clk);
    m_sel = v;
    expect_now();
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    m_reset();
    m_sel = 1'b0;
    repeat (2) @(negedge clk);
    phase_nm = "reset";
    expect_now();
    rst_n = 1'b1;
    @(negedge clk);

    phase_nm = "run_count";
    repeat (59) step(0);

    // latency: unchanged after SYNC edges, updated on the next edge
    phase_nm = "lat_hold";
    one_hz = 1'b1;
    repeat (SYNC) @(negedge clk);
    expect_now();
    phase_nm = "lat_carry";
    @(negedge clk);
    m_sec();
    expect_now();
    one_hz = 1'b0;
    repeat (LAT) @(negedge clk);

    phase_nm = "adj_to_1234";
    set_sel(1'b0);
    set_adj(1'b1);
    while (m_mm != 12) step(1);
    set_sel(1'b1);
    while (m_ss != 34) step(1);
    set_adj(1'b0);
    step(2);

    phase_nm = "async_reset";
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 m_reset();
    expect_now();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_sel(1'b0);

    phase_nm = "pause";
    repeat (5) step(0);
    step(2);
    repeat (3) step(0);
    phase_nm = "resume";
    step(2);
    step(0);

    phase_nm = "same_cycle";
    repeat (4) step(0);
    step(3);
    step(2);

    phase_nm = "adj_sec";
    while (m_ss != 58) step(0);
    set_sel(1'b1);
    set_adj(1'b1);
    repeat (48) step(1);
    repeat (2) step(0);
    step(2);
    set_adj(1'b0);

    phase_nm = "blink";
    set_sel(1'b0);
    set_adj(1'b1);
    repeat (20) step(1);
    set_sel(1'b1);
    repeat (6) step(1);
    set_adj(1'b0);

    phase_nm = "max_wrap";
    set_sel(1'b0);
    set_adj(1'b1);
    while (m_mm != MAXM) step(1);
    set_sel(1'b1);
    while (m_ss != 59) step(1);
    set_adj(1'b0);
    step(2);
    step(0);

    phase_nm = "random";
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 7);
      case (r)
        0: step(0);
        1, 2, 3: step(1);
        4: step(2);
        5: step(3);
        6: set_adj(!adj);
        default: set_sel(!sel);
      endcase
    end

    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- MM:SS stopwatch counter, directly downstream of the master clock divider.
- Consumes the divider's slow square-wave outputs (one_hz, thirty_two_hz), which are levels toggling in the clk domain, not pulses.
- Rising edges drive the seconds count and adjust-mode timing.
- Produces four BCD digits plus blink flags for the downstream 7-segment display driver.

Parameters:
- MAX_MIN, 59, highest minutes value before minutes wrap to 00; legal 1..99.
- ADJ_DIV, 16, thirty_two_hz rising edges per adjust increment (16 gives 2 increments/s).
- SYNC_STAGES, 2, synchroniser flops on each slow input; legal value ≥2.

Ports:
- clk  in  1  system clock, same clock as the divider.
- rst_n  in  1  asynchronous, active-low reset.
- one_hz  in  1  1 Hz square wave from the divider.
- thirty_two_hz  in  1  32 Hz square wave from the divider.
- pause_btn  in  1  debounced level; each rising edge toggles run/pause.
- adj  in  1  level; high selects adjust mode.
- sel  in  1  adjust target: 0 = minutes, 1 = seconds.
- min_tens  out  4  BCD.
- min_ones  out  4  BCD.
- sec_tens  out  4  BCD.
- sec_ones  out  4  BCD.
- running  out  1  high in RUN.
- blink_min  out  1  minutes digits blank phase.
- blink_sec  out  1  seconds digits blank phase.

Behaviour:
- Reset (async assert, sync release):
  - all digits 0, state RUN, running=1;
  - blink outputs 0, synchroniser/edge registers 0, adjust and blink dividers 0.
- Input conditioning:
  - one_hz, thirty_two_hz and pause_btn each pass through SYNC_STAGES flops, then a previous-value flop.
  - tick = sync & ~prev (rising edges only).
  - Latency: input rise → registered effect on the (SYNC_STAGES+1)th clk rising edge.
- States:
  - RUN: sec_tick increments MM:SS.
  - PAUSED: counts held.
  - ADJUST: entered whenever adj=1 from any state; adj has priority.
  - adj falling → PAUSED. pause edge toggles RUN↔PAUSED and is ignored in ADJUST.
- Counting:
  - Seconds 00..59; 59→00 carries +1 into minutes.
  - Minutes 00..MAX_MIN; MAX_MIN→00 with no carry out.
  - Digits always valid BCD; ones digit 9→0 carries into tens.
- Adjust:
  - adj_div counts thirty_two_hz ticks 0..ADJ_DIV-1 and clears on ADJUST entry.
  - On reaching ADJ_DIV-1 with a tick, the selected field +1 and adj_div→0.
  - Seconds wrap 59→00 in ADJUST without carrying into minutes.
  - sec_tick ignored in ADJUST.
  - sel change mid-ADJUST does not clear adj_div.
- Simultaneous events: sec_tick and pause edge in the same cycle → count applied per the current state (RUN counts), then the state changes.
- blink:
  - blink_phase toggles every 8 thirty_two_hz ticks (2 Hz blink).
  - blink_min = ADJUST & ~sel & blink_phase.
  - blink_sec = ADJUST & sel & blink_phase.
  - Both are 0 outside ADJUST.
- Reset asserted mid-operation: immediate return to reset values; no partial carry survives.

Optional Feature:
- STOPWATCH_BLINK_EN defined: blink divider and blink_min/blink_sec behave as above.
- Undefined: blink divider removed; blink_min and blink_sec are tied 0; all else identical.

Decomposition:
- stopwatch_pkg:
  - state enum {RUN, PAUSED, ADJUST};
  - BCD_W=4;
  - SEC_MAX=59;
  - BLINK_DIV=8.
- Sub-module bcd2_counter: two-digit BCD counter with wrap-value input, inc, and carry_out (asserted on wrap when inc); instantiated for seconds and minutes.
- Edge detectors stay inline.

Test Plan:
- Reset with rst_n=0 mid-count at 12:34 → next cycle digits 00:00, running=1, blink 0 with no clk edge required.
- RUN at 00:59, one one_hz rise → 01:00 exactly SYNC_STAGES+1 edges after the rise; at MAX_MIN:59 → 00:00.
- pause_btn rise at 00:05 → running=0; 3 one_hz rises leave 00:05; second pause rise → resumes, next rise gives 00:06.
- adj=1, sel=1 from 00:58, 48 thirty_two_hz rises → 3 increments: 00:59, 00:00, 00:01, minutes unchanged; one_hz rises ignored; drop adj → PAUSED.
- Same-cycle pause edge and sec_tick in RUN at 00:10 → 00:11 and PAUSED.
- With STOPWATCH_BLINK_EN, ADJUST sel=0 → blink_min toggles every 8 thirty_two_hz rises, blink_sec=0; without macro both stay 0.
